// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue front end.
//   PQ_CMD_PUSH / PQ_CMD_POP : encoding of q_write on the queue command port
//   grant_t                  : which side the arbiter served most recently
package pq_pkg;

    localparam logic PQ_CMD_PUSH = 1'b1;
    localparam logic PQ_CMD_POP  = 1'b0;

    typedef enum logic {
        GRANT_POP  = 1'b0,
        GRANT_PUSH = 1'b1
    } grant_t;

endpackage

// File: rtl/pq_skid_buffer.sv
// Two-entry in-order buffer between the queue's pop response and the
// consumer stream.
//   clk, rst              : clock, asynchronous active-high reset
//   up_valid/up_ready/up_data : response side (from the queue)
//   dn_valid/dn_ready/dn_data : consumer side (head of buffer)
//   drain_ok              : buffer will be empty after this cycle, i.e. a
//                           newly issued pop cannot collide with held data
module pq_skid_buffer
    import pq_pkg::*;
#(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [DATA_LENGTH-1:0] up_data,
    output logic                   dn_valid,
    input  logic                   dn_ready,
    output logic [DATA_LENGTH-1:0] dn_data,
    output logic                   drain_ok
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       wr_en;
    logic       rd_en;

    assign up_ready = (count_reg != 2'd2);
    assign dn_valid = (count_reg != 2'd0);
    assign wr_en    = up_valid && up_ready;
    assign rd_en    = dn_valid && dn_ready;

    // A lone head entry that leaves this cycle counts as empty, so the
    // arbiter can overlap the next pop with the current hand-off.
    assign drain_ok = (count_reg == 2'd0) || ((count_reg == 2'd1) && dn_ready);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_LENGTH-1:0] data_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= up_data;
                end
            end
        end
    endgenerate

    assign dn_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (rd_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pq_frontend.sv
// Stream front end for an external priority queue: arbitrates producer
// pushes against consumer pops, tracks the one-cycle pop response, keeps an
// occupancy count and a sticky protocol-error flag.
//   clk, rst                           : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data             : producer push stream
//   m_valid/m_ready/m_data             : consumer pop stream (smallest first)
//   q_valid_cmd/q_write/q_data_cmd     : command to the queue (1=push, 0=pop)
//   q_full/q_empty                     : queue flags for the current command
//   q_rvalid/q_rdata                   : pop response, one cycle after pop
//   o_count                            : elements held in the queue
//   o_err                              : sticky response-protocol error
module pq_frontend
    import pq_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int QUEUE_DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_LENGTH-1:0]       s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_LENGTH-1:0]       m_data,
    output logic                         q_valid_cmd,
    output logic                         q_write,
    output logic [DATA_LENGTH-1:0]       q_data_cmd,
    input  logic                         q_full,
    input  logic                         q_empty,
    input  logic                         q_rvalid,
    input  logic [DATA_LENGTH-1:0]       q_rdata,
    output logic [$clog2(QUEUE_DEPTH):0] o_count,
    output logic                         o_err
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    grant_t        last_grant_reg;
    logic          in_flight_reg;
    logic          guard_reg;
    logic          err_reg;
    logic [CW-1:0] count_reg;

    logic push_eligible;
    logic pop_eligible;
    logic push_issue;
    logic pop_issue;
    logic rsp_valid;
    logic skid_up_ready;
    logic skid_drain_ok;

    // Commands are suppressed while reset is held so the queue never sees
    // a request from an uninitialised arbiter.
    assign push_eligible = !rst && s_valid && !q_full;
    assign pop_eligible  = !rst && m_ready && !q_empty && skid_drain_ok && !in_flight_reg;

    always_comb begin
        push_issue = 1'b0;
        pop_issue  = 1'b0;
        if (push_eligible && pop_eligible) begin
            if (last_grant_reg == GRANT_POP) begin
                push_issue = 1'b1;
            end else begin
                pop_issue = 1'b1;
            end
        end else if (push_eligible) begin
            push_issue = 1'b1;
        end else if (pop_eligible) begin
            pop_issue = 1'b1;
        end
    end

    assign q_valid_cmd = push_issue || pop_issue;
    assign q_write     = push_issue ? PQ_CMD_PUSH : PQ_CMD_POP;
    assign q_data_cmd  = push_issue ? s_data : '0;
    assign s_ready     = push_issue;

    // Only responses we asked for enter the buffer; strays just flag an error.
    assign rsp_valid = q_rvalid && in_flight_reg;

    pq_skid_buffer #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .up_valid (rsp_valid),
        .up_ready (skid_up_ready),
        .up_data  (q_rdata),
        .dn_valid (m_valid),
        .dn_ready (m_ready),
        .dn_data  (m_data),
        .drain_ok (skid_drain_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= GRANT_POP;
            in_flight_reg  <= 1'b0;
            guard_reg      <= 1'b1;
            err_reg        <= 1'b0;
            count_reg      <= '0;
        end else begin
            // guard_reg masks stray responses left over from before reset
            // during the first cycle after release.
            guard_reg <= 1'b0;

            if (push_issue) begin
                last_grant_reg <= GRANT_PUSH;
            end else if (pop_issue) begin
                last_grant_reg <= GRANT_POP;
            end

            // Pops are never back to back, so the flag lives exactly one cycle.
            in_flight_reg <= pop_issue;

            if (push_issue) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop_issue) begin
                count_reg <= count_reg - CW'(1);
            end

            if ((q_rvalid && !in_flight_reg && !guard_reg) ||
                (in_flight_reg && !q_rvalid) ||
                (rsp_valid && !skid_up_ready)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign o_count = count_reg;
    assign o_err   = err_reg;

endmodule
